// File: rtl/uart_cmd_line_framer.sv
// uart_cmd_line_framer
//
// Drains the UART RX FIFO one byte at a time and assembles a CR/LF
// terminated ASCII command line into an internal buffer. A finished line is
// held behind a valid/ready handshake together with its length and the
// position of the first comma, so the dispatcher parses a stable frame
// instead of raw FIFO bytes.
//
// Ports:
//   clock            system clock (27 MHz)
//   reset            synchronous, active-high
//   rx_fifo_empty    RX FIFO empty flag
//   rx_fifo_data_out RX FIFO head byte (first-word-fall-through)
//   rx_fifo_read_en  single-cycle pop strobe
//   cmd_valid        a complete line is held
//   cmd_ready        dispatcher accepts the held line
//   cmd_len          number of bytes in the held line
//   cmd_comma_pos    index of the first ',' (MAX_CMD_LENGTH when none)
//   cmd_has_comma    held line contains a ','
//   cmd_rd_addr      buffer read address
//   cmd_rd_data      buffer[cmd_rd_addr], 8'h00 at or beyond cmd_len
//   err_overflow     one-cycle pulse when a line is discarded for length
//   err_timeout      one-cycle pulse when a partial line goes stale

module uart_cmd_line_framer #(
    parameter int MAX_CMD_LENGTH = 32,
    parameter int TIMEOUT_CYCLES = 270000,
    parameter int LEN_W          = $clog2(MAX_CMD_LENGTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_fifo_empty,
    input  logic [7:0]       rx_fifo_data_out,
    output logic             rx_fifo_read_en,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [LEN_W-1:0] cmd_len,
    output logic [LEN_W-1:0] cmd_comma_pos,
    output logic             cmd_has_comma,
    input  logic [LEN_W-1:0] cmd_rd_addr,
    output logic [7:0]       cmd_rd_data,
    output logic             err_overflow,
    output logic             err_timeout
);

    localparam int AW = (MAX_CMD_LENGTH > 1) ? $clog2(MAX_CMD_LENGTH) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CMD_LENGTH);
    localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]       state;
    logic [LEN_W-1:0] wr_index;
    logic [LEN_W-1:0] comma_pos;
    logic             has_comma;
    logic [TW-1:0]    idle_count;
    logic             pop_q;
    logic [7:0]       buffer [MAX_CMD_LENGTH];

    logic pop;
    logic is_term;
    logic is_bs;
    logic is_comma;
    logic store_byte;

    // A pop is never issued in the cycle right after another one, which gives
    // the FWFT FIFO a full cycle to present its next head byte.
    assign pop = !reset && !pop_q && !rx_fifo_empty &&
                 ((state == ST_COLLECT) || (state == ST_DISCARD));
    assign rx_fifo_read_en = pop;
    assign cmd_valid       = (state == ST_HOLD);

    assign is_term  = (rx_fifo_data_out == 8'h0D) || (rx_fifo_data_out == 8'h0A);
    assign is_bs    = (rx_fifo_data_out == 8'h08);
    assign is_comma = (rx_fifo_data_out == 8'h2C);

    assign store_byte = pop && (state == ST_COLLECT) && !is_term && !is_bs &&
                        (wr_index < MAX_LEN);

    // Buffer storage has no reset; its contents only matter below cmd_len.
    always_ff @(posedge clock) begin
        if (store_byte) begin
            buffer[wr_index[AW-1:0]] <= rx_fifo_data_out;
        end
    end

    // Reads outside the held line return zero, which also hides stale or
    // in-progress bytes whenever no line is held (cmd_len is 0 then).
    always_comb begin
        cmd_rd_data = 8'h00;
        if (cmd_rd_addr < cmd_len) begin
            cmd_rd_data = buffer[cmd_rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_COLLECT;
            wr_index      <= '0;
            comma_pos     <= MAX_LEN;
            has_comma     <= 1'b0;
            idle_count    <= '0;
            pop_q         <= 1'b0;
            cmd_len       <= '0;
            cmd_comma_pos <= MAX_LEN;
            cmd_has_comma <= 1'b0;
            err_overflow  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            pop_q        <= pop;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;

            case (state)
                ST_COLLECT: begin
                    if (pop) begin
                        idle_count <= '0;
                        if (is_term) begin
                            // Terminators on an empty line are swallowed so
                            // CR LF yields a single frame.
                            if (wr_index != '0) begin
                                cmd_len       <= wr_index;
                                cmd_comma_pos <= comma_pos;
                                cmd_has_comma <= has_comma;
                                state         <= ST_HOLD;
                            end
                        end else if (is_bs) begin
                            if (wr_index != '0) begin
                                wr_index <= wr_index - 1'b1;
                                // Only the first comma is tracked, so erasing
                                // it means no comma survives before it.
                                if (has_comma && (comma_pos == wr_index - 1'b1)) begin
                                    has_comma <= 1'b0;
                                    comma_pos <= MAX_LEN;
                                end
                            end
                        end else if (wr_index < MAX_LEN) begin
                            wr_index <= wr_index + 1'b1;
                            if (is_comma && !has_comma) begin
                                has_comma <= 1'b1;
                                comma_pos <= wr_index;
                            end
                        end else begin
                            err_overflow <= 1'b1;
                            wr_index     <= '0;
                            has_comma    <= 1'b0;
                            comma_pos    <= MAX_LEN;
                            state        <= ST_DISCARD;
                        end
                    end else if (wr_index != '0) begin
                        // A terminator pop takes the branch above, so it
                        // always beats a timeout firing in the same cycle.
                        if (idle_count == TO_LAST) begin
                            err_timeout <= 1'b1;
                            wr_index    <= '0;
                            idle_count  <= '0;
                            has_comma   <= 1'b0;
                            comma_pos   <= MAX_LEN;
                        end else begin
                            idle_count <= idle_count + 1'b1;
                        end
                    end else begin
                        idle_count <= '0;
                    end
                end

                ST_DISCARD: begin
                    idle_count <= '0;
                    if (pop && is_term) begin
                        state <= ST_COLLECT;
                    end
                end

                ST_HOLD: begin
                    idle_count <= '0;
                    if (cmd_ready) begin
                        state         <= ST_COLLECT;
                        wr_index      <= '0;
                        has_comma     <= 1'b0;
                        comma_pos     <= MAX_LEN;
                        cmd_len       <= '0;
                        cmd_comma_pos <= MAX_LEN;
                        cmd_has_comma <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
